mem_arbiter: RTL
================

# mem_arbiter

Single-port arbiter for the CPU's 4096 × 32 word RAM. It shares the RAM between two requesters: the instruction-fetch port (read-only) and the load/store data port (read/write). It uses round-robin arbitration, a 1-cycle synchronous RAM read latency and out-of-range address detection. It sits between the `fetcher`/load-store logic in `cpu` and the RAM array, and replaces direct `ram[]` indexing.

## Interface
Parameters:
- `DATA_W`, 32, word width.
- `RAM_AW`, 12, RAM word-address width (depth = 2^RAM_AW).
- `ADDR_W`, 32, requester word-address width.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `if_valid`  in  1  fetch request valid.
- `if_ready`  out  1  fetch request granted this cycle.
- `if_addr`  in  ADDR_W  fetch word address.
- `if_rsp_valid`  out  1  fetch response valid.
- `if_rsp_data`  out  DATA_W  fetch read data.
- `if_rsp_err`  out  1  fetch address out of range.
- `d_valid`  in  1  data request valid.
- `d_ready`  out  1  data request granted this cycle.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data word address.
- `d_wdata`  in  DATA_W  store data.
- `d_rsp_valid`  out  1  data response valid (load data or store ack).
- `d_rsp_data`  out  DATA_W  load data.
- `d_rsp_err`  out  1  data address out of range.
- `ram_en`  out  1  RAM access enable.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  RAM_AW  RAM word address.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data, valid the cycle after `ram_en && !ram_we`.

## Operation
- Handshake: a request transfers when valid && ready in the same cycle.
  - Requesters hold valid and payload stable until ready.
  - valid must not depend combinationally on ready.
- Grant is combinational from the two valids and `last_grant`:
  - One valid → that requester is granted.
  - Both valid → the requester that is not `last_grant` is granted.
  - None valid → no grant; `ram_en` = 0.
- `last_grant` updates only on a grant. Reset value is DATA, so fetch wins the first contention after reset.
- Range check: a request is in range iff `addr[ADDR_W-1:RAM_AW]` == 0.
  - Granted in-range request: `ram_en` = 1, `ram_we` = `d_we` (0 for fetch), `ram_addr` = `addr[RAM_AW-1:0]`, `ram_wdata` = `d_wdata`.
  - Granted out-of-range request: still consumes the grant slot and updates `last_grant`, but `ram_en` = 0 and `ram_we` = 0.
- Response register captures owner, is_read and err at grant.
- Response cycle (grant + 1): the owner's `*_rsp_valid` = 1.
  - `*_rsp_data` = `ram_rdata` for an in-range read, else 0.
  - `*_rsp_err` = err.
  - Stores always produce an ack response.
- Responses cannot be back-pressured; requesters must accept them.
- Non-owner `*_rsp_valid` = 0 and its data = 0.

## Timing
- Reset values (asserted asynchronously): all `*_rsp_valid`, `*_rsp_err` and `*_rsp_data` = 0; `last_grant` = DATA.
- `ram_en`, `ram_we` and both readies are combinational but gated to 0 while `rst_n` = 0.
- Read latency: 1 cycle from grant to response. Throughput: one grant per cycle total across both ports.
- Back-to-back: with both valids continuously high, grants alternate IF, D, IF, D, …; neither requester waits more than 1 cycle.
- Store at cycle T followed by a load of the same address at T+1: the load returns the new data (RAM write completes at the T edge).
- Reset mid-operation: a pending response is dropped (no `rsp_valid` after reset release) and the next grant follows the reset `last_grant`.
- An out-of-range request and an in-range request never overlap, because there is one grant per cycle.

## Structure
- Package `mem_arb_pkg` holds:
  - `RAM_AW`/`DATA_W` defaults.
  - enum `owner_t` {`OWN_IF`, `OWN_D`}.
  - struct `rsp_slot_t` {valid, owner, is_read, err}.
- Sub-module `rr_pick2`: 2-way round-robin pick plus the `last_grant` flop.
- The range check and response register stay in `mem_arbiter`.

## Test plan
- Fetch only: `if_addr` = 0x10 with RAM[0x10] = 0xDEADBEEF → `if_ready` same cycle; next cycle `if_rsp_valid` = 1, data 0xDEADBEEF, err 0.
- Contention: both valid for 4 cycles directly after reset → grants IF, D, IF, D; `last_grant` = DATA at the end.
- Store then load: `d_we` = 1, addr 0x7FF, wdata 0x12345678; then a load of 0x7FF → store ack (data 0), then load returns 0x12345678.
- Out of range: `d_addr` = 0x1000 load → `ram_en` = 0; next cycle `d_rsp_valid` = 1, `d_rsp_err` = 1, data 0; a following in-range fetch is still granted normally.
- Reset mid-op: assert `rst_n` = 0 in the cycle after a fetch grant → `if_rsp_valid` stays 0 through and after release; the first contention after release grants IF.
- Idle: no valids → `ram_en` = 0 and no response ever asserted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared defaults and types for the RAM arbiter
package mem_arb_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_RAM_AW = 12;
    typedef enum logic {OWN_IF, OWN_D} owner_t;
    typedef struct packed {
        logic   valid;
        owner_t owner;
        logic   is_read;
        logic   err;
    } rsp_slot_t;
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick with the last-grant flop
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_if,
    input  logic req_d,
    output logic gnt_if,
    output logic gnt_d
);
    owner_t last_grant;
    // on contention the side that was not granted last wins
    always_comb begin
        gnt_if = req_if && (!req_d || last_grant == OWN_D);
        gnt_d  = req_d && (!req_if || last_grant == OWN_IF);
    end
    // remember the winner; reset favours fetch on the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= OWN_D;
        else if (gnt_if || gnt_d)
            last_grant <= gnt_d ? OWN_D : OWN_IF;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous RAM port between fetch and load/store
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RAM_AW = DEF_RAM_AW,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              if_rsp_err,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              d_rsp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    logic              gnt_if, gnt_d, gnt, in_range, rd_ok;
    logic [ADDR_W-1:0] sel_addr;
    rsp_slot_t         slot;

    rr_pick2 u_pick (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_if (if_valid && rst_n),
        .req_d  (d_valid && rst_n),
        .gnt_if (gnt_if),
        .gnt_d  (gnt_d)
    );

    // route the granted request to the RAM; out-of-range grants leave the RAM idle
    always_comb begin
        sel_addr  = gnt_d ? d_addr : if_addr;
        in_range  = sel_addr[ADDR_W-1:RAM_AW] == '0;
        gnt       = gnt_if || gnt_d;
        if_ready  = gnt_if;
        d_ready   = gnt_d;
        ram_en    = gnt && in_range;
        ram_we    = ram_en && gnt_d && d_we;
        ram_addr  = sel_addr[RAM_AW-1:0];
        ram_wdata = d_wdata;
    end

    // capture who owns next cycle's response and what kind it is
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            slot <= '0;
        else
            slot <= '{valid: gnt, owner: gnt_d ? OWN_D : OWN_IF,
                      is_read: gnt_if || !d_we, err: !in_range};
    end

    // steer RAM read data to the owner; everything else reads as zero
    always_comb begin
        rd_ok        = slot.valid && slot.is_read && !slot.err;
        if_rsp_valid = slot.valid && slot.owner == OWN_IF;
        d_rsp_valid  = slot.valid && slot.owner == OWN_D;
        if_rsp_data  = (if_rsp_valid && rd_ok) ? ram_rdata : '0;
        d_rsp_data   = (d_rsp_valid && rd_ok) ? ram_rdata : '0;
        if_rsp_err   = if_rsp_valid && slot.err;
        d_rsp_err    = d_rsp_valid && slot.err;
    end
endmodule
